// File: rtl/if_prefetch_pkg.sv
// Shared definitions for the instruction-fetch prefetch unit.
// Holds the fetch FSM state type, the word/address widths, the width of one
// queue entry ({pc, instr}) and the program counter value used after reset.
package if_prefetch_pkg;

    localparam int WORD_W  = 16;
    localparam int ADDR_W  = 16;
    localparam int ENTRY_W = ADDR_W + WORD_W;

    localparam logic [ADDR_W-1:0] RESET_PC = 16'h0000;

    // IDLE: nothing outstanding; WAIT: outstanding, data kept;
    // DROP: outstanding, data discarded on arrival (stream was redirected).
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } pf_state_t;

endpackage

// File: rtl/if_prefetch_queue.sv
// pf_queue: DEPTH-entry FIFO of {pc, instr} pairs feeding decode.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   push        write push_data at the tail (caller guarantees a free slot)
//   push_data   {pc, instr}
//   pop         remove head entry (ignored when empty)
//   flush       empty the queue; overrides push and pop in the same cycle
//   count       number of valid entries, 0..DEPTH
//   head        entry at the read pointer
module pf_queue
    import if_prefetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [ENTRY_W-1:0]       push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output logic [ENTRY_W-1:0]       head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               do_pop;

    assign do_pop = pop && (count != '0);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush)
            mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/if_prefetch.sv
// if_prefetch: instruction prefetcher between instruction memory and decode.
// Issues one read at a time to imem, queues returned words with their address
// and presents the queue head to decode. A redirect flushes the queue and
// restarts fetching at redirect_pc; a read already in flight is completed on
// the memory side but its data is discarded.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   imem_req/imem_addr         read request and word address (held until ack)
//   imem_ack/imem_rdata        one-cycle completion pulse and read data
//   redirect/redirect_pc       one-cycle new-stream pulse and target address
//   hlt                        level; blocks new requests only
//   id_valid/id_instr/id_pc    queue head towards decode
//   id_ready                   decode consumes the head this cycle
module if_prefetch
    import if_prefetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [WORD_W-1:0] imem_rdata,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              hlt,
    output logic              id_valid,
    output logic [WORD_W-1:0] id_instr,
    output logic [ADDR_W-1:0] id_pc,
    input  logic              id_ready
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    pf_state_t           state, state_nx;
    logic [ADDR_W-1:0]   fpc, fpc_nx;
    logic [ADDR_W-1:0]   req_addr, req_addr_nx;
    logic [CNT_W-1:0]    count;
    logic [ENTRY_W-1:0]  head;
    logic                push;
    logic                pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            fpc      <= RESET_PC;
            req_addr <= RESET_PC;
        end else begin
            state    <= state_nx;
            fpc      <= fpc_nx;
            req_addr <= req_addr_nx;
        end
    end

    // A request is only launched while a slot is free (count is not reduced
    // by a same-cycle pop), so the returning word can always be pushed.
    always_comb begin
        state_nx    = state;
        fpc_nx      = fpc;
        req_addr_nx = req_addr;
        push        = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (redirect) begin
                    fpc_nx = redirect_pc;
                end else if (!hlt && (count < CNT_W'(DEPTH))) begin
                    state_nx    = ST_WAIT;
                    req_addr_nx = fpc;
                end
            end
            ST_WAIT: begin
                if (redirect) begin
                    fpc_nx   = redirect_pc;
                    state_nx = imem_ack ? ST_IDLE : ST_DROP;
                end else if (imem_ack) begin
                    push     = 1'b1;
                    fpc_nx   = fpc + ADDR_W'(1);
                    state_nx = ST_IDLE;
                end
            end
            ST_DROP: begin
                if (redirect)
                    fpc_nx = redirect_pc;
                if (imem_ack)
                    state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign imem_req  = (state != ST_IDLE);
    assign imem_addr = req_addr;

    assign id_valid = (count != '0);
    assign pop      = id_valid && id_ready;

    pf_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({fpc, imem_rdata}),
        .pop       (pop),
        .flush     (redirect),
        .count     (count),
        .head      (head)
    );

    // Head fields are forced to zero when empty so reset values are defined
    // without resetting the storage array.
    assign id_pc    = id_valid ? head[ENTRY_W-1 -: ADDR_W] : '0;
    assign id_instr = id_valid ? head[WORD_W-1:0] : '0;

endmodule

// File: tb/tb_if_prefetch.sv
// Bench for if_prefetch: transaction-level model (queue of {pc, instr} plus
// one outstanding-request record) checked every cycle, directed scenarios
// with literal expectations, then randomized traffic.
module tb_if_prefetch;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_rdata = '0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic        hlt = 1'b0;
    logic        id_valid;
    logic [15:0] id_instr;
    logic [15:0] id_pc;
    logic        id_ready = 1'b0;

    if_prefetch #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .hlt         (hlt),
        .id_valid    (id_valid),
        .id_instr    (id_instr),
        .id_pc       (id_pc),
        .id_ready    (id_ready)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Model: queue contents and the single outstanding request.
    logic [15:0] m_pc[$];
    logic [15:0] m_in[$];
    logic [15:0] m_fpc  = '0;
    logic [15:0] m_addr = '0;
    bit          m_out  = 1'b0;
    bit          m_drop = 1'b0;

    // Memory responder state.
    bit          mem_busy = 1'b0;
    int          mem_wait = 0;
    int          mem_lat  = 0;
    int          n_ack    = 0;
    bit          lat_rand = 1'b0;
    logic [15:0] slow_addr = 16'h7777;
    logic [15:0] first_ack_data = '0;

    // Log of instructions accepted by decode.
    logic [15:0] acc_pc[$];
    int          acc_cyc[$];

    function automatic void chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    task automatic model_reset();
        m_pc.delete();
        m_in.delete();
        m_fpc  = 16'h0000;
        m_addr = 16'h0000;
        m_out  = 1'b0;
        m_drop = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs presented now.
    task automatic model_update();
        int cnt;
        bit do_pop;
        cnt    = m_pc.size();
        do_pop = (cnt != 0) && id_ready;
        if (redirect) begin
            m_pc.delete();
            m_in.delete();
            m_fpc = redirect_pc;
            if (m_out && imem_ack) begin
                m_out  = 1'b0;
                m_drop = 1'b0;
            end else if (m_out) begin
                m_drop = 1'b1;
            end
        end else begin
            if (do_pop) begin
                void'(m_pc.pop_front());
                void'(m_in.pop_front());
            end
            if (m_out) begin
                if (imem_ack) begin
                    if (!m_drop) begin
                        m_pc.push_back(m_addr);
                        m_in.push_back(imem_rdata);
                        m_fpc = m_addr + 16'd1;
                    end
                    m_out  = 1'b0;
                    m_drop = 1'b0;
                end
            end else if (!hlt && cnt < DEPTH) begin
                m_out  = 1'b1;
                m_addr = m_fpc;
            end
        end
    endtask

    task automatic check_all();
        chk("imem_req", 16'(imem_req), 16'(m_out));
        chk("imem_addr", imem_addr, m_addr);
        chk("id_valid", 16'(id_valid), 16'(m_pc.size() != 0));
        if (m_pc.size() != 0) begin
            chk("id_pc", id_pc, m_pc[0]);
            chk("id_instr", id_instr, m_in[0]);
        end
    endtask

    task automatic mem_drive();
        imem_ack = 1'b0;
        if (rst_n && imem_req) begin
            if (!mem_busy) begin
                mem_busy = 1'b1;
                mem_wait = 0;
                if (lat_rand)
                    mem_lat = int'($urandom_range(0, 3));
                else
                    mem_lat = (imem_addr == slow_addr) ? 3 : 0;
            end
            if (mem_wait >= mem_lat) begin
                imem_ack   = 1'b1;
                imem_rdata = 16'($urandom);
                mem_busy   = 1'b0;
                if (n_ack == 0)
                    first_ack_data = imem_rdata;
                n_ack++;
            end else begin
                mem_wait++;
            end
        end
    endtask

    task automatic tick();
        if (id_valid && id_ready && !redirect) begin
            acc_pc.push_back(id_pc);
            acc_cyc.push_back(cyc);
        end
        model_update();
        @(posedge clk);
        #1;
        cyc++;
        n_vec++;
        redirect = 1'b0;
        check_all();
        mem_drive();
    endtask

    // Asserts reset with a spurious ack present, checks outputs immediately,
    // and releases it leaving the spurious ack up for the first cycle.
    task automatic do_reset();
        rst_n      = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 16'hDEAD;
        redirect   = 1'b0;
        hlt        = 1'b0;
        mem_busy   = 1'b0;
        #1;
        chk("rst_imem_req", 16'(imem_req), 16'h0000);
        chk("rst_imem_addr", imem_addr, 16'h0000);
        chk("rst_id_valid", 16'(id_valid), 16'h0000);
        chk("rst_id_instr", id_instr, 16'h0000);
        chk("rst_id_pc", id_pc, 16'h0000);
        model_reset();
        repeat (2) begin
            @(posedge clk);
            #1;
            cyc++;
            check_all();
        end
        rst_n = 1'b1;
    endtask

    task automatic clear_log();
        acc_pc.delete();
        acc_cyc.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;

        // Zero-wait memory, decode always ready: 0,1,2,3 one every 2 cycles.
        lat_rand = 1'b0;
        id_ready = 1'b1;
        do_reset();
        clear_log();
        tick();
        chk("A_first_req", 16'(imem_req), 16'h0001);
        chk("A_first_addr", imem_addr, 16'h0000);
        repeat (12) tick();
        chk("A_accepted_ge4", 16'(acc_pc.size() >= 4), 16'h0001);
        if (acc_pc.size() >= 4) begin
            for (int i = 0; i < 4; i++)
                chk("A_seq_pc", acc_pc[i], 16'(i));
            for (int i = 0; i < 3; i++)
                chk("A_spacing", 16'(acc_cyc[i+1] - acc_cyc[i]), 16'd2);
        end

        // Decode stalled: exactly DEPTH acks, then no request, head held.
        id_ready = 1'b0;
        do_reset();
        n_ack = 0;
        repeat (20) tick();
        chk("B_acks", 16'(n_ack), 16'd4);
        chk("B_req_idle", 16'(imem_req), 16'h0000);
        chk("B_head_instr", id_instr, first_ack_data);
        chk("B_head_pc", id_pc, 16'h0000);
        id_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (imem_req) found = 1'b1;
        end
        chk("B_resume_seen", 16'(found), 16'h0001);
        chk("B_resume_addr", imem_addr, 16'h0004);

        // Redirect while 0x0005 is outstanding with a slow ack.
        slow_addr = 16'h0005;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (imem_req && imem_addr == 16'h0005) found = 1'b1;
        end
        chk("C_req5_seen", 16'(found), 16'h0001);
        clear_log();
        redirect    = 1'b1;
        redirect_pc = 16'h0040;
        tick();
        chk("C_drop_req", 16'(imem_req), 16'h0001);
        chk("C_drop_addr", imem_addr, 16'h0005);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (imem_req && imem_addr != 16'h0005) found = 1'b1;
        end
        chk("C_new_req_seen", 16'(found), 16'h0001);
        chk("C_new_addr", imem_addr, 16'h0040);
        repeat (6) tick();
        chk("C_accepted", 16'(acc_pc.size() != 0), 16'h0001);
        if (acc_pc.size() != 0)
            chk("C_first_pc", acc_pc[0], 16'h0040);

        // Redirect coincident with ack and pop.
        slow_addr = 16'h7777;
        id_ready  = 1'b0;
        do_reset();
        repeat (5) tick();
        id_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (imem_ack && id_valid) found = 1'b1;
        end
        chk("D_coincide_seen", 16'(found), 16'h0001);
        clear_log();
        redirect    = 1'b1;
        redirect_pc = 16'h0100;
        tick();
        chk("D_flushed", 16'(id_valid), 16'h0000);
        repeat (10) tick();
        chk("D_accepted", 16'(acc_pc.size() != 0), 16'h0001);
        if (acc_pc.size() != 0)
            chk("D_first_pc", acc_pc[0], 16'h0100);
        foreach (acc_pc[i])
            chk("D_no_old", 16'(acc_pc[i] >= 16'h0100), 16'h0001);

        // Address wrap after redirect near the top of the space.
        do_reset();
        repeat (3) tick();
        clear_log();
        redirect    = 1'b1;
        redirect_pc = 16'hFFFE;
        tick();
        repeat (12) tick();
        chk("E_accepted_ge3", 16'(acc_pc.size() >= 3), 16'h0001);
        if (acc_pc.size() >= 3) begin
            chk("E_pc0", acc_pc[0], 16'hFFFE);
            chk("E_pc1", acc_pc[1], 16'hFFFF);
            chk("E_pc2", acc_pc[2], 16'h0000);
        end

        // hlt during WAIT, then reset in the middle of a request.
        slow_addr = 16'h0002;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (imem_req && imem_addr == 16'h0002) found = 1'b1;
        end
        chk("F_req2_seen", 16'(found), 16'h0001);
        hlt = 1'b1;
        clear_log();
        repeat (10) tick();
        chk("F_hlt_req", 16'(imem_req), 16'h0000);
        chk("F_drained", 16'(id_valid), 16'h0000);
        chk("F_acc_one", 16'(acc_pc.size()), 16'd1);
        if (acc_pc.size() != 0)
            chk("F_last_pc", acc_pc[acc_pc.size()-1], 16'h0002);
        hlt       = 1'b0;
        slow_addr = 16'h0003;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (imem_req && imem_addr == 16'h0003) found = 1'b1;
        end
        chk("F_req3_seen", 16'(found), 16'h0001);
        do_reset();
        tick();
        chk("F_restart_req", 16'(imem_req), 16'h0001);
        chk("F_restart_addr", imem_addr, 16'h0000);

        // Randomized traffic against the model.
        lat_rand  = 1'b1;
        slow_addr = 16'h7777;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            id_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 31) == 0)
                hlt = ~hlt;
            if ($urandom_range(0, 15) == 0) begin
                redirect = 1'b1;
                if ($urandom_range(0, 1) == 0)
                    redirect_pc = 16'hFFFC + 16'($urandom_range(0, 3));
                else
                    redirect_pc = 16'($urandom);
            end
            if ($urandom_range(0, 799) == 0)
                do_reset();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/if_prefetch.md
IF_PREFETCH -- requirements
Module: if_prefetch

Interface
REQ-001: Parameter DEPTH, default 4, is the prefetch queue entries (power of 2, 2..16).
REQ-002: clk  input  1  clock; all state updates on rising edge.
REQ-003: rst_n  input  1  reset, asynchronous, active-low.
REQ-004: imem_req  output  1  instruction-memory read request.
REQ-005: imem_addr  output  16  word address of the current request.
REQ-006: imem_ack  input  1  one-cycle pulse; imem_rdata valid this cycle.
REQ-007: imem_rdata  input  16  instruction word.
REQ-008: redirect  input  1  one-cycle pulse from jump/call/branch resolution.
REQ-009: redirect_pc  input  16  new fetch address, sampled with redirect.
REQ-010: hlt  input  1  level; suppresses new requests.
REQ-011: id_valid  output  1  queue head holds a valid instruction for decode.
REQ-012: id_instr  output  16  head instruction.
REQ-013: id_pc  output  16  address of head instruction.
REQ-014: id_ready  input  1  decode accepts head this cycle.

Function
REQ-015: Internal fetch pointer fpc (16 bit) is the address of the next request; it increments by 1 per accepted ack, wrapping 0xFFFF->0x0000.
REQ-016: FSM states: IDLE (no outstanding request), WAIT (request outstanding, data kept), DROP (request outstanding, data to be discarded).
REQ-017: IDLE->WAIT when hlt=0, redirect=0 and count<DEPTH; imem_req=1 and imem_addr=fpc from that cycle.
REQ-018: In WAIT/DROP, imem_req stays 1 and imem_addr stays constant until the imem_ack cycle; the request is never withdrawn.
REQ-019: WAIT+ack, no redirect: push {fpc, imem_rdata}, fpc+=1, go to IDLE; the next request is issued no earlier than the following cycle.
REQ-020: Slot reservation: a request is issued only if count<DEPTH, so an ack always finds a free slot; push and pop in the same cycle are both performed.
REQ-021: Pop occurs when id_valid=1 and id_ready=1; id_valid=(count!=0); id_instr/id_pc are head fields, held stable while id_ready=0.
REQ-022: redirect in any state: queue flushed (count=0, id_valid=0 next cycle), fpc=redirect_pc; the same-cycle pop and push are discarded.
REQ-023: redirect in WAIT without same-cycle ack -> DROP; redirect in IDLE, or coincident with ack -> IDLE.
REQ-024: DROP+ack: data discarded, fpc unchanged, -> IDLE; a second redirect while in DROP overwrites fpc and stays in DROP.
REQ-025: hlt=1: no new request from IDLE; an outstanding WAIT completes and is pushed; the queue continues draining to decode; redirect still honoured.
REQ-026: count is clog2(DEPTH)+1 bits; read/write pointers wrap modulo DEPTH.

Reset
REQ-027: On rst_n=0, immediately: state=IDLE, fpc=0x0000, count=0, pointers=0, imem_req=0, imem_addr=0x0000, id_valid=0, id_instr=0x0000, id_pc=0x0000.
REQ-028: Reset mid-request abandons it; any ack arriving during or in the first cycle after reset release is ignored.
REQ-029: First request (addr 0x0000) is issued in the first clock edge after rst_n deasserts, if hlt=0.

Structure
REQ-030: Shared package holds the FSM state encoding (IDLE/WAIT/DROP), the 16-bit word/address width constants and the reset PC constant 0x0000.
REQ-031: One sub-module, pf_queue: synchronous DEPTH x 32-bit FIFO storing {pc, instr} with push, pop, flush, count outputs.

Verification
REQ-032: Reset release, zero-wait memory (ack the cycle after req), id_ready=1 -> id_pc sequence 0,1,2,3... with one instruction every 2 cycles.
REQ-033: id_ready=0, DEPTH=4 -> exactly 4 acks accepted, imem_req stays 0 afterwards, id_instr held; raise id_ready -> fetching resumes at 0x0004.
REQ-034: Redirect to 0x0040 while request for 0x0005 is outstanding (ack 3 cycles later) -> that data dropped, next imem_addr=0x0040, first id_pc=0x0040.
REQ-035: Redirect coincident with ack and with a pop -> queue empty the next cycle, no entry from the old stream ever reaches id_valid.
REQ-036: Redirect to 0xFFFE, free-running -> id_pc 0xFFFE, 0xFFFF, 0x0000.
REQ-037: hlt=1 raised during WAIT -> outstanding word enqueued and drained, then imem_req=0 while hlt=1; rst_n pulse mid-WAIT -> outputs return to reset values immediately.
